frog_mover: RTL and testbench

FROG_MOVER -- requirements
Module: frog_mover

---
 rtl/frog_mover.sv | 203 ++++++++++++++++++++
 tb/tb_frog_mover.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/frog_mover.sv
// -----------------------------------------------------------------------------
// frog_mover
//
// Moves a frog sprite one grid cell per accepted button press. The move is
// applied on the next frame boundary, so the sprite never tears mid-frame.
// Each button is synchronized, optionally debounced, and edge-detected.
// A press arms a move. The move is applied on the next vsync rising edge. The
// FSM then waits until every button is released before it accepts another
// press, so a button that stays held gives only one move.
//
// Build option:
//   FROG_DEBOUNCE_EN  - when defined, each button has its own debounce counter.
//                       When undefined, the synchronized level is used directly
//                       and DEBOUNCE_CYCLES is ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_up     in   raw button, active-high
//   btn_down   in   raw button, active-high
//   btn_left   in   raw button, active-high
//   btn_right  in   raw button, active-high
//   vsync      in   frame sync from the display stage, active-high
//   frog_x     out  [9:0] left pixel coordinate of the frog
//   frog_y     out  [9:0] top pixel coordinate of the frog
//   moved      out  one-cycle pulse when the position actually changes
//   at_goal    out  high while the frog is in row 0
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for a press
//   PENDING | direction latched, waiting for the next vsync rising edge
//   HOLD    | move done, waiting for all buttons released
// -----------------------------------------------------------------------------
module frog_mover #(
    parameter int GRID_SIZE       = 32,
    parameter int H_CELLS         = 20,
    parameter int V_CELLS         = 15,
    parameter int START_COL       = 9,
    parameter int START_ROW       = 14,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       vsync,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic       moved,
    output logic       at_goal
);

    typedef enum logic [1:0] {IDLE, PENDING, HOLD} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [4:0] COL_RST  = 5'(START_COL);
    localparam logic [3:0] ROW_RST  = 4'(START_ROW);
    localparam logic [4:0] COL_LAST = 5'(H_CELLS - 1);
    localparam logic [3:0] ROW_LAST = 4'(V_CELLS - 1);
    localparam logic [9:0] X_RST    = 10'(START_COL * GRID_SIZE);
    localparam logic [9:0] Y_RST    = 10'(START_ROW * GRID_SIZE);

    // Button bit order: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0] btn_raw;
    logic [3:0] btn_s1, btn_s2;
    logic [3:0] btn_lvl;
    logic [3:0] btn_lvl_d;
    logic [3:0] press;

    logic vs_s1, vs_s2, vs_d, vs_rise;

    state_t     state, state_n;
    dir_t       dir, dir_n;
    logic [4:0] col, col_n;
    logic [3:0] row, row_n;
    logic       moved_n;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchronizers. The vsync rise detect is registered as well.
    // This puts the position update three edges after vsync is first sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_d    <= 1'b0;
            vs_rise <= 1'b0;
        end else begin
            btn_s1  <= btn_raw;
            btn_s2  <= btn_s1;
            vs_s1   <= vsync;
            vs_s2   <= vs_s1;
            vs_d    <= vs_s2;
            vs_rise <= vs_s2 & ~vs_d;
        end
    end

`ifdef FROG_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // Count consecutive samples that disagree with the accepted level.
        // Flip the level on the last sample of the run.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (btn_s2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                lvl <= btn_s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign btn_lvl[i] = lvl;
    end
`else
    assign btn_lvl = btn_s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_lvl_d <= '0;
        end else begin
            btn_lvl_d <= btn_lvl;
        end
    end

    assign press = btn_lvl & ~btn_lvl_d;

    always_comb begin
        state_n = state;
        dir_n   = dir;
        col_n   = col;
        row_n   = row;
        moved_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (|press) begin
                    state_n = PENDING;
                    if (press[0])      dir_n = DIR_UP;
                    else if (press[1]) dir_n = DIR_DOWN;
                    else if (press[2]) dir_n = DIR_LEFT;
                    else               dir_n = DIR_RIGHT;
                end
            end
            PENDING: begin
                if (vs_rise) begin
                    state_n = HOLD;
                    unique case (dir)
                        DIR_UP:    if (row != 4'd0)   row_n = row - 4'd1;
                        DIR_DOWN:  if (row != ROW_LAST) row_n = row + 4'd1;
                        DIR_LEFT:  if (col != 5'd0)   col_n = col - 5'd1;
                        DIR_RIGHT: if (col != COL_LAST) col_n = col + 5'd1;
                        default:   ;
                    endcase
                    moved_n = (row_n != row) || (col_n != col);
                end
            end
            HOLD: begin
                if (btn_lvl == 4'b0000) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // The pixel outputs are computed from the next cell. They therefore change
    // on the same edge as col/row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= DIR_UP;
            col     <= COL_RST;
            row     <= ROW_RST;
            frog_x  <= X_RST;
            frog_y  <= Y_RST;
            moved   <= 1'b0;
            at_goal <= (START_ROW == 0);
        end else begin
            state   <= state_n;
            dir     <= dir_n;
            col     <= col_n;
            row     <= row_n;
            frog_x  <= 10'(int'(col_n) * GRID_SIZE);
            frog_y  <= 10'(int'(row_n) * GRID_SIZE);
            moved   <= moved_n;
            at_goal <= (row_n == 4'd0);
        end
    end

endmodule

// File: tb/tb_frog_mover.sv
module tb_frog_mover;

    localparam int GRID = 32;
    localparam int HC   = 20;
    localparam int VC   = 15;
    localparam int SC   = 9;
    localparam int SR   = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] frog_x, frog_y;
    logic       moved, at_goal;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frog position in cells.
    int m_col, m_row;

    frog_mover #(
        .GRID_SIZE(GRID), .H_CELLS(HC), .V_CELLS(VC),
        .START_COL(SC), .START_ROW(SR), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .vsync(vsync),
        .frog_x(frog_x), .frog_y(frog_y), .moved(moved), .at_goal(at_goal)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, " x"}, 32'(frog_x), 32'(m_col * GRID));
        check({tag, " y"}, 32'(frog_y), 32'(m_row * GRID));
        check({tag, " goal"}, 32'(at_goal), 32'(m_row == 0));
    endtask

    task automatic set_btns(input logic [3:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
    endtask

    // Apply one move from a set of buttons that were pressed together.
    // Up has the highest priority, then down, left and right. The move
    // clamps at the playfield edges. Returns 1 if the position changed.
    function automatic bit model_move(input logic [3:0] m);
        int c = m_col, r = m_row;
        if (m[0])      r = (r > 0) ? r - 1 : r;
        else if (m[1]) r = (r < VC - 1) ? r + 1 : r;
        else if (m[2]) c = (c > 0) ? c - 1 : c;
        else if (m[3]) c = (c < HC - 1) ? c + 1 : c;
        model_move = (c != m_col) || (r != m_row);
        m_col = c;
        m_row = r;
    endfunction

    // Pulse vsync and watch the update window. The position must be unchanged
    // through the second edge after vsync is first sampled. The new position
    // and the moved pulse appear at the third edge. moved drops one cycle later.
    task automatic vsync_step(input string tag, input int old_c, input int old_r, input bit exp_mv);
        vsync = 1'b1;
        tick(1);
        tick(1);
        vsync = 1'b0;
        tick(1);
        check({tag, " pre x"}, 32'(frog_x), 32'(old_c * GRID));
        check({tag, " pre y"}, 32'(frog_y), 32'(old_r * GRID));
        check({tag, " pre mv"}, 32'(moved), 32'(0));
        tick(1);
        check_pos(tag);
        check({tag, " mv"}, 32'(moved), 32'(exp_mv));
        tick(1);
        check({tag, " mv end"}, 32'(moved), 32'(0));
        tick(3);
    endtask

    // Press a set of buttons and wait for debounce. Pulse vsync, then release.
    task automatic do_move(input string tag, input logic [3:0] m);
        int oc = m_col, orow = m_row;
        bit mv;
        set_btns(m);
        tick(10);
        mv = model_move(m);
        vsync_step(tag, oc, orow, mv);
        set_btns(4'b0000);
        tick(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_col = SC;
        m_row = SR;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [3:0] m;
        bit mv;
        int oc, orow;

        m_col = SC;
        m_row = SR;

        // Reset values.
        rst = 1'b1;
        #1;
        check_pos("rst async");
        check("rst mv", 32'(moved), 32'(0));
        tick(3);
        rst = 1'b0;
        tick(2);
        check_pos("rst");
        check("rst x const", 32'(frog_x), 32'(288));
        check("rst y const", 32'(frog_y), 32'(448));

        // Hold up: one move. Three more vsyncs while it is held give nothing.
        set_btns(4'b0001);
        tick(10);
        oc = m_col; orow = m_row;
        mv = model_move(4'b0001);
        vsync_step("up", oc, orow, mv);
        check("up y const", 32'(frog_y), 32'(416));
        for (int i = 0; i < 3; i++) vsync_step("up held", m_col, m_row, 1'b0);
        set_btns(4'b0000);
        tick(10);

        // A 2-cycle glitch on right is rejected when debounce is built in.
        btn_right = 1'b1;
        tick(2);
        btn_right = 1'b0;
        tick(10);
        oc = m_col; orow = m_row;
`ifdef FROG_DEBOUNCE_EN
        mv = 1'b0;
`else
        mv = model_move(4'b1000);
`endif
        vsync_step("glitch", oc, orow, mv);

        // Down at the bottom row clamps. The FSM must then return to IDLE, so
        // the next up press is accepted.
        do_reset();
        do_move("down clamp", 4'b0010);
        do_move("after clamp", 4'b0001);

        // Up and left together: up wins. Walk up to the goal row, then clamp.
        do_reset();
        do_move("up+left", 4'b0101);
        check("up+left x", 32'(frog_x), 32'(288));
        for (int i = 0; i < 13; i++) do_move("climb", 4'b0001);
        check("goal y", 32'(frog_y), 32'(0));
        check("goal flag", 32'(at_goal), 32'(1));
        do_move("top clamp", 4'b0001);

        // Reset in PENDING discards the pending move.
        do_reset();
        set_btns(4'b0001);
        tick(10);
        set_btns(4'b0000);
        tick(2);
        do_reset();
        tick(10);
        vsync_step("rst pending", m_col, m_row, 1'b0);

        // A button held through reset is pressed once its debounce completes.
        set_btns(4'b1000);
        do_reset();
        tick(10);
        oc = m_col; orow = m_row;
        mv = model_move(4'b1000);
        vsync_step("held rst", oc, orow, mv);
        set_btns(4'b0000);
        tick(10);

        // Random button combinations against the reference model.
        for (int i = 0; i < 24; i++) begin
            m = 4'($urandom_range(1, 15));
            do_move("rand", m);
            if ($urandom_range(0, 3) == 0) begin
                vsync_step("rand idle", m_col, m_row, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
